// File: rtl/step_pulse_sequencer.sv
// Step pulse sequencer: selects one of the free-running time_up square waves,
// turns its rising edges into single-cycle step pulses while running, and
// advances a wrapping position counter and a speed level for the game logic.
`timescale 1ns/1ps

module step_pulse_sequencer #(
    parameter int NUM_RATES = 12,
    parameter int SEL_W     = 4,
    parameter int POS_MAX   = 15,
    parameter int POS_W     = 4,
    parameter int MAX_LEVEL = 7,
    parameter int LVL_W     = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_RATES-1:0] rate_in,
    input  logic [SEL_W-1:0]     base_rate,
    input  logic                 auto_speedup,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 stop,
    output logic                 timer_enable,
    output logic                 step,
    output logic [POS_W-1:0]     position,
    output logic [LVL_W-1:0]     level,
    output logic [SEL_W-1:0]     rate_sel,
    output logic                 running,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;
    logic                   fresh_start;
    logic [NUM_RATES-1:0]   rate_q;
    logic [2**SEL_W-1:0]    rate_pad;
    logic [SEL_W-1:0]       base_reg;
    logic [SEL_W:0]         sel_sum;
    logic [SEL_W-1:0]       sel_next;
    logic                   prev_reg;
    logic                   cur;
    logic                   sel_change;
    logic                   edge_hit;
    logic                   at_top;
    logic                   at_max;

    // Pad the registered rate bank to the full select range so any index is legal;
    // unused slots read as constant 0.
    for (genvar gi = 0; gi < 2**SEL_W; gi++) begin : g_pad
        if (gi < NUM_RATES) begin : g_live
            assign rate_pad[gi] = rate_q[gi];
        end else begin : g_tie
            assign rate_pad[gi] = 1'b0;
        end
    end

    // Rate index = base + level, clamped to the fastest line, edge qualification.
    always_comb begin
        sel_sum    = {1'b0, base_reg} + (SEL_W+1)'(level);
        sel_next   = (sel_sum > (SEL_W+1)'(NUM_RATES-1)) ? SEL_W'(NUM_RATES-1)
                                                         : sel_sum[SEL_W-1:0];
        cur        = rate_pad[rate_sel];
        sel_change = (sel_next != rate_sel);
        at_top     = (position == POS_W'(POS_MAX));
        at_max     = (level == LVL_W'(MAX_LEVEL));
        // No step on the edge that leaves RUN, nor while the selected line is switching.
        edge_hit   = (state_reg == RUN) & ~stop & ~pause & cur & ~prev_reg & ~sel_change;
    end

    // Next-state logic; stop beats pause beats start.
    always_comb begin
        state_next  = state_reg;
        fresh_start = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!stop && start) begin
                    state_next  = RUN;
                    fresh_start = 1'b1;
                end
            end
            RUN: begin
                if (stop)                         state_next = IDLE;
                else if (pause)                   state_next = PAUSE;
                else if (edge_hit && at_top && at_max) state_next = DONE;
            end
            PAUSE: begin
                if (stop)       state_next = IDLE;
                else if (pause) state_next = PAUSE;
                else if (start) state_next = RUN;
            end
            DONE: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (start) begin
                    state_next  = RUN;
                    fresh_start = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Input capture, rate select, edge history and the step pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rate_q   <= '0;
            rate_sel <= '0;
            prev_reg <= 1'b0;
            step     <= 1'b0;
        end else begin
            rate_q   <= rate_in;
            rate_sel <= sel_next;
            // Track the line that will be selected next cycle, so a select change
            // starts edge detection from that line's current level.
            prev_reg <= rate_pad[sel_next];
            step     <= edge_hit;
        end
    end

    // Position, level and base rate bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            position <= '0;
            level    <= '0;
            base_reg <= '0;
        end else if (stop) begin
            position <= '0;
            level    <= '0;
        end else if (fresh_start) begin
            position <= '0;
            level    <= '0;
            base_reg <= base_rate;
        end else if (edge_hit) begin
            position <= at_top ? '0 : position + POS_W'(1);
            if (at_top && auto_speedup && !at_max)
                level <= level + LVL_W'(1);
        end
    end

    // Status decode; timer_enable drops as soon as the state leaves RUN.
    assign running      = (state_reg == RUN);
    assign timer_enable = (state_reg == RUN);
    assign done         = (state_reg == DONE);

endmodule
